prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Upstream feeder of the shared 6-bit-address, 9-bit-data program memory.
- Accepts a length-prefixed word stream over a valid/ready handshake and writes the words into memory on consecutive addresses from BASE_ADDR.
- Holds the CPU in reset until the load completes, then releases it.
- Owns the memory A/DATA/WRITE/READ bus only while busy; the top level muxes it with the CPU bus using busy.

Parameters:
- AW, 6, address width; memory depth 2^AW.
- DW, 9, data word width.
- BASE_ADDR, 0, first address written; wraps modulo 2^AW.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a load session; ignored while busy=1.
- in_valid  in  1  stream word valid.
- in_data  in  DW  stream word.
- in_ready  out  1  loader accepts in_data this cycle.
- A  out  AW  memory address.
- DATA  out  DW  memory write data.
- WRITE  out  1  memory write strobe; one word per cycle high.
- READ  out  1  memory read strobe; used only with the optional feature.
- D  in  DW  memory read data; valid while READ=1, sampled on the rising edge ending that cycle.
- busy  out  1  loader owns the memory bus.
- done  out  1  load finished; held until the next start.
- cpu_hold  out  1  CPU reset request.
- err  out  1  verify mismatch; optional feature only.

Behaviour:
- Reset values (rst sampled high on a clk edge):
  - A=0, DATA=0, WRITE=0, READ=0, in_ready=0, busy=0, done=0, err=0, cpu_hold=1.
  - FSM goes to IDLE.
  - Rst overrides any in-flight transfer. Memory contents are left partial; the bench must not assume rollback.
- Handshake: a word is accepted on an edge where in_valid=1 and in_ready=1. in_valid may stay high across cycles.
- IDLE:
  - in_ready=0.
  - start=1 -> HDR: busy=1, done=0, cpu_hold=1, err=0, idx=0, chk=0.
- HDR:
  - in_ready=1.
  - First accepted word sets N = in_data[AW-1:0]; 0 encodes 2^AW. Upper bits are ignored.
  - Next state is LOAD.
- LOAD:
  - in_ready=1 while fewer than N words have been accepted.
  - Each accepted word is registered. On the next cycle: WRITE=1, A = (BASE_ADDR + idx) mod 2^AW, DATA = word, idx increments, chk ^= word.
  - Throughput is 1 word/cycle. Back-to-back accepts give contiguous WRITE pulses.
  - WRITE=0 in any cycle without a pending word.
  - in_ready drops in the cycle after the Nth accept.
  - After the Nth write cycle -> FIN.
- FIN:
  - One cycle: busy=0, done=1, cpu_hold=0.
  - A, DATA, WRITE, READ go to 0. Then -> IDLE.
  - done and cpu_hold keep their values until the next start or rst.
- Latency: start to in_ready=1 is 1 cycle. Last accept to the last WRITE is 1 cycle. Last WRITE to done=1 is 1 cycle.
- A wrap-around past 2^AW-1 returns to address 0. This is legal and not an error.
- start asserted while busy=1 has no effect.

Optional Feature:
- Macro: PROG_LOADER_VERIFY_EN.
- Defined:
  - After the Nth write, go to VERIFY instead of FIN.
  - VERIFY issues N cycles with READ=1 and WRITE=0. A steps from BASE_ADDR (mod 2^AW).
  - D is sampled at the end of each cycle and XORed into rchk.
  - One compare cycle follows: err = (rchk != chk). Then -> FIN.
  - VERIFY adds N+1 cycles of latency. cpu_hold stays 1 throughout.
  - err holds its value until the next start or rst.
- Not defined: no VERIFY state exists, READ is tied to 0, and err is tied to 0.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 and start=1.
  - Expect A=0, DATA=0, WRITE=0, READ=0, in_ready=0, busy=0, done=0, cpu_hold=1.
- Basic load: start, then stream 3, 0x1A5, 0x0F0, 0x123 with in_valid continuously high.
  - Expect WRITE high for 3 consecutive cycles at A=0,1,2 with DATA=0x1A5, 0x0F0, 0x123.
  - done=1 and cpu_hold=0 one cycle after the last WRITE.
- Stalls: the same stream with in_valid low for 2 cycles between words.
  - Expect WRITE pulses only on the cycles after accepts, with A/DATA unchanged from the no-stall case.
  - in_ready=0 after the 3rd accept.
- Wrap: BASE_ADDR=62, header 0x100 (N=0 -> 64 words).
  - Expect writes at A=62,63,0,1,...,61 and 64 WRITE cycles total.
  - A header of 0x005 is treated as N=5.
- Reset mid-load: assert rst after the 2nd of 4 words.
  - Expect WRITE=0 and busy=0 on the next edge, with done=0.
  - A fresh start then completes normally.
- With PROG_LOADER_VERIFY_EN: load 2 words, then have the bench memory corrupt address 1 before readback.
  - Expect 2 READ cycles at A=0,1, then err=1 and done=1.
  - An uncorrupted run gives err=0.

Source files
------------

// File: rtl/prog_loader.sv
// Program loader: takes a length-prefixed word stream, writes it to program memory from BASE_ADDR, holds the CPU meanwhile.
// Latency: start->in_ready 1 cycle, accept->WRITE 1 cycle, last WRITE->done 1 cycle (+N+1 with PROG_LOADER_VERIFY_EN readback).
// Backpressure: in_ready is low outside HDR/LOAD and once N words are taken; in_valid may be held high across cycles.
module prog_loader #(
  parameter int AW        = 6,
  parameter int DW        = 9,
  parameter int BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [AW-1:0] A,
  output logic [DW-1:0] DATA,
  output logic          WRITE,
  output logic          READ,
  input  logic [DW-1:0] D,
  output logic          busy,
  output logic          done,
  output logic          cpu_hold,
  output logic          err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_LOAD = 3'd2;
  localparam logic [2:0] S_FIN  = 3'd3;
`ifdef PROG_LOADER_VERIFY_EN
  localparam logic [2:0] S_VER  = 3'd4;
  localparam logic [2:0] S_CMP  = 3'd5;
`endif

  localparam logic [AW-1:0] BASE = AW'(BASE_ADDR);
  // Header value 0 stands for a full memory image of 2^AW words.
  localparam logic [AW:0] FULL_N = {1'b1, {AW{1'b0}}};

  logic [2:0]    state;
  logic [AW:0]   n;      // words in this session, 1..2^AW
  logic [AW:0]   idx;    // words accepted (LOAD) / reads issued (VERIFY)
  logic [DW-1:0] chk;    // XOR of every word written
  logic [AW:0]   hdr_n;
  logic          accept;

  assign accept = in_valid & in_ready;

  // Header decode: only the low AW bits carry the length.
  always_comb begin
    hdr_n = {1'b0, in_data[AW-1:0]};
    if (in_data[AW-1:0] == '0) hdr_n = FULL_N;
  end

  // Ready while waiting for the header or while payload words are still owed.
  always_comb begin
    in_ready = 1'b0;
    if (state == S_HDR) in_ready = 1'b1;
    else if (state == S_LOAD && idx < n) in_ready = 1'b1;
  end

`ifdef PROG_LOADER_VERIFY_EN
  logic [DW-1:0] rchk;   // XOR of every word read back
`else
  logic          unused_d;
  assign unused_d = ^D;
  assign READ = 1'b0;
  assign err  = 1'b0;
`endif

  // Session FSM; all bus outputs are registered so the memory sees clean strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      A        <= '0;
      DATA     <= '0;
      WRITE    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cpu_hold <= 1'b1;
      n        <= '0;
      idx      <= '0;
      chk      <= '0;
`ifdef PROG_LOADER_VERIFY_EN
      READ     <= 1'b0;
      err      <= 1'b0;
      rchk     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_FIN: begin
          state <= S_IDLE;
          if (start) begin
            state    <= S_HDR;
            busy     <= 1'b1;
            done     <= 1'b0;
            cpu_hold <= 1'b1;
            idx      <= '0;
            chk      <= '0;
`ifdef PROG_LOADER_VERIFY_EN
            err      <= 1'b0;
            rchk     <= '0;
`endif
          end
        end
        S_HDR: begin
          if (accept) begin
            n     <= hdr_n;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (idx == n) begin
            // This cycle carries the last write; next cycle leaves the load phase.
            WRITE <= 1'b0;
            DATA  <= '0;
`ifdef PROG_LOADER_VERIFY_EN
            state <= S_VER;
            READ  <= 1'b1;
            A     <= BASE;
            idx   <= '0;
`else
            state    <= S_FIN;
            A        <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            cpu_hold <= 1'b0;
`endif
          end else if (accept) begin
            WRITE <= 1'b1;
            A     <= BASE + idx[AW-1:0];
            DATA  <= in_data;
            idx   <= idx + 1'b1;
            chk   <= chk ^ in_data;
          end else begin
            WRITE <= 1'b0;
          end
        end
`ifdef PROG_LOADER_VERIFY_EN
        S_VER: begin
          rchk <= rchk ^ D;
          idx  <= idx + 1'b1;
          if (idx == n - 1'b1) begin
            READ  <= 1'b0;
            A     <= '0;
            state <= S_CMP;
          end else begin
            A <= A + 1'b1;
          end
        end
        S_CMP: begin
          err      <= (rchk != chk);
          state    <= S_FIN;
          busy     <= 1'b0;
          done     <= 1'b1;
          cpu_hold <= 1'b0;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances (BASE_ADDR 0 and 62) run the same stream in lockstep.
// Each has a small behavioural memory so the optional readback path sees real data.
module tb_prog_loader;

`ifdef PROG_LOADER_VERIFY_EN
  localparam int VEXTRA = 1;
`else
  localparam int VEXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst, start, in_valid;
  logic [8:0] in_data;

  logic       rdy0, wr0, rd0, busy0, done0, hold0, err0;
  logic [5:0] a0;
  logic [8:0] dat0, d0;
  logic       rdy1, wr1, rd1, busy1, done1, hold1, err1;
  logic [5:0] a1;
  logic [8:0] dat1, d1;

  logic [8:0] mem0 [64];
  logic [8:0] mem1 [64];
  bit corrupt = 1'b0;
  int wcnt1 = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_loader #(.AW(6), .DW(9), .BASE_ADDR(0)) u0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .A(a0), .DATA(dat0), .WRITE(wr0), .READ(rd0), .D(d0),
    .busy(busy0), .done(done0), .cpu_hold(hold0), .err(err0));

  prog_loader #(.AW(6), .DW(9), .BASE_ADDR(62)) u1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .A(a1), .DATA(dat1), .WRITE(wr1), .READ(rd1), .D(d1),
    .busy(busy1), .done(done1), .cpu_hold(hold1), .err(err1));

  // Memory models; corrupt flips bit 0 of anything written to address 1 of mem0.
  always @(posedge clk) begin
    if (wr0) mem0[a0] <= (corrupt && a0 == 6'd1) ? (dat0 ^ 9'h001) : dat0;
    if (wr1) mem1[a1] <= dat1;
  end
  assign d0 = rd0 ? mem0[a0] : 9'h000;
  assign d1 = rd1 ? mem1[a1] : 9'h000;

  always @(negedge clk) if (wr1) wcnt1 <= wcnt1 + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Present a word and return once it has been accepted (ok=0 if never accepted).
  task automatic send_word(input logic [8:0] w, output bit ok);
    in_valid = 1'b1;
    in_data  = w;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rdy0) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done0 && cyc < 300) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 9'h003;
    tick(); tick();
    checks++; if (a0 !== 6'd0 || a1 !== 6'd0) begin errors++; $display("FAIL reset_A got %h/%h exp 00", a0, a1); end
    checks++; if (dat0 !== 9'd0) begin errors++; $display("FAIL reset_DATA got %h exp 000", dat0); end
    checks++; if ({wr0, rd0, rdy0} !== 3'b000) begin errors++; $display("FAIL reset_strobes got WRITE/READ/in_ready %b exp 000", {wr0, rd0, rdy0}); end
    checks++; if ({busy0, done0, hold0, err0} !== 4'b0010) begin errors++; $display("FAIL reset_status got busy/done/hold/err %b exp 0010", {busy0, done0, hold0, err0}); end
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [8:0] w [3] = '{9'h1A5, 9'h0F0, 9'h123};
    logic [5:0] ea1 [3] = '{6'd62, 6'd63, 6'd0};
    bit ok;
    int cyc;
    do_start();
    checks++; if ({rdy0, busy0, done0, hold0} !== 4'b1101) begin errors++; $display("FAIL basic_start got rdy/busy/done/hold %b exp 1101", {rdy0, busy0, done0, hold0}); end
    in_valid = 1'b1;
    send_word(9'h003, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_hdr accepted %0d exp 1", ok); end
    for (int i = 0; i < 3; i++) begin
      send_word(w[i], ok);
      checks++;
      if (!ok || wr0 !== 1'b1 || a0 !== 6'(i) || dat0 !== w[i] || a1 !== ea1[i]) begin
        errors++;
        $display("FAIL basic_write%0d got ok=%0d WRITE=%b A=%0d DATA=%h A1=%0d exp 1 1 %0d %h %0d", i, ok, wr0, a0, dat0, a1, i, w[i], ea1[i]);
      end
    end
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL basic_ready_drop got %b exp 0", rdy0); end
    wait_done(cyc);
    checks++; if (cyc != 1 + VEXTRA * 4) begin errors++; $display("FAIL basic_done_latency got %0d exp %0d", cyc, 1 + VEXTRA * 4); end
    checks++; if ({busy0, done0, hold0, err0, wr0, rd0, a0, dat0} !== {4'b0100, 2'b00, 6'd0, 9'd0}) begin
      errors++; $display("FAIL basic_fin got busy/done/hold/err %b WRITE/READ %b A=%0d DATA=%h exp 0100 00 0 000", {busy0, done0, hold0, err0}, {wr0, rd0}, a0, dat0);
    end
    tick(); tick();
    checks++; if ({done0, hold0} !== 2'b10) begin errors++; $display("FAIL basic_done_held got done/hold %b exp 10", {done0, hold0}); end
  endtask

  task automatic test_stall();
    logic [8:0] w [3] = '{9'h1A5, 9'h0F0, 9'h123};
    bit ok;
    int cyc;
    do_start();
    send_word(9'h003, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_hdr accepted %0d exp 1", ok); end
    for (int i = 0; i < 3; i++) begin
      send_word(w[i], ok);
      checks++;
      if (!ok || wr0 !== 1'b1 || a0 !== 6'(i) || dat0 !== w[i]) begin
        errors++; $display("FAIL stall_write%0d got ok=%0d WRITE=%b A=%0d DATA=%h exp 1 1 %0d %h", i, ok, wr0, a0, dat0, i, w[i]);
      end
      if (i < 2) begin
        start = 1'b1;   // must be ignored mid-load
        tick();
        start = 1'b0;
        checks++; if (wr0 !== 1'b0 || rdy0 !== 1'b1 || busy0 !== 1'b1) begin errors++; $display("FAIL stall_gap%0d_a got WRITE/rdy/busy %b exp 011", i, {wr0, rdy0, busy0}); end
        tick();
        checks++; if (wr0 !== 1'b0 || rdy0 !== 1'b1) begin errors++; $display("FAIL stall_gap%0d_b got WRITE/rdy %b exp 01", i, {wr0, rdy0}); end
      end
    end
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL stall_ready_drop got %b exp 0", rdy0); end
    wait_done(cyc);
    checks++; if (cyc != 1 + VEXTRA * 4 || hold0 !== 1'b0 || err0 !== 1'b0) begin
      errors++; $display("FAIL stall_done got cycles=%0d hold=%b err=%b exp %0d 0 0", cyc, hold0, err0, 1 + VEXTRA * 4);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int cyc;
    int bad;
    logic [8:0] wd;
    do_start();
    wcnt1 = 0;
    bad = 0;
    send_word(9'h100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_hdr accepted %0d exp 1", ok); end
    for (int i = 0; i < 64; i++) begin
      wd = 9'(i * 7 + 1);
      in_valid = 1'b1;
      send_word(wd, ok);
      if (!ok || wr1 !== 1'b1 || a1 !== 6'(62 + i) || dat1 !== wd || a0 !== 6'(i)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL wrap_writes got %0d bad of 64 exp 0", bad); end
    checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL wrap_ready_drop got %b exp 0", rdy0); end
    wait_done(cyc);
    checks++; if (cyc != 1 + VEXTRA * 65 || wcnt1 != 64) begin
      errors++; $display("FAIL wrap_total got cycles=%0d writes=%0d exp %0d 64", cyc, wcnt1, 1 + VEXTRA * 65);
    end
    do_start();
    wcnt1 = 0;
    send_word(9'h005, ok);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      send_word(9'h050 + 9'(i), ok);
    end
    checks++; if (rdy0 !== 1'b0 || a1 !== 6'd2 || dat1 !== 9'h054) begin
      errors++; $display("FAIL hdr5_last got rdy=%b A1=%0d DATA=%h exp 0 2 054", rdy0, a1, dat1);
    end
    in_valid = 1'b1;
    in_data = 9'h1FF;
    wait_done(cyc);
    in_valid = 1'b0;
    checks++; if (cyc != 1 + VEXTRA * 6 || wcnt1 != 5) begin
      errors++; $display("FAIL hdr5_total got cycles=%0d writes=%0d exp %0d 5", cyc, wcnt1, 1 + VEXTRA * 6);
    end
  endtask

  task automatic test_midreset();
    bit ok;
    int cyc;
    do_start();
    send_word(9'h004, ok);
    send_word(9'h011, ok);
    send_word(9'h022, ok);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({wr0, busy0, done0, hold0, rdy0} !== 5'b00010) begin
      errors++; $display("FAIL midreset got WRITE/busy/done/hold/rdy %b exp 00010", {wr0, busy0, done0, hold0, rdy0});
    end
    tick();
    do_start();
    send_word(9'h001, ok);
    send_word(9'h055, ok);
    checks++; if (!ok || wr0 !== 1'b1 || a0 !== 6'd0 || dat0 !== 9'h055) begin
      errors++; $display("FAIL midreset_reload got ok=%0d WRITE=%b A=%0d DATA=%h exp 1 1 0 055", ok, wr0, a0, dat0);
    end
    wait_done(cyc);
    checks++; if (cyc != 1 + VEXTRA * 2 || hold0 !== 1'b0) begin
      errors++; $display("FAIL midreset_done got cycles=%0d hold=%b exp %0d 0", cyc, hold0, 1 + VEXTRA * 2);
    end
  endtask

`ifdef PROG_LOADER_VERIFY_EN
  task automatic test_verify();
    bit ok;
    int cyc;
    corrupt = 1'b1;
    do_start();
    send_word(9'h002, ok);
    send_word(9'h0AA, ok);
    send_word(9'h155, ok);
    checks++; if (!ok || wr0 !== 1'b1 || a0 !== 6'd1) begin errors++; $display("FAIL verify_write got ok=%0d WRITE=%b A=%0d exp 1 1 1", ok, wr0, a0); end
    tick();
    checks++; if ({rd0, wr0, hold0, busy0} !== 4'b1011 || a0 !== 6'd0) begin
      errors++; $display("FAIL verify_read0 got READ/WRITE/hold/busy %b A=%0d exp 1011 0", {rd0, wr0, hold0, busy0}, a0);
    end
    tick();
    checks++; if (rd0 !== 1'b1 || a0 !== 6'd1) begin errors++; $display("FAIL verify_read1 got READ=%b A=%0d exp 1 1", rd0, a0); end
    tick();
    checks++; if ({rd0, done0, hold0} !== 3'b001) begin errors++; $display("FAIL verify_cmp got READ/done/hold %b exp 001", {rd0, done0, hold0}); end
    tick();
    checks++; if ({done0, err0, hold0} !== 3'b110) begin errors++; $display("FAIL verify_corrupt got done/err/hold %b exp 110", {done0, err0, hold0}); end
    corrupt = 1'b0;
    do_start();
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL verify_err_clear got %b exp 0", err0); end
    send_word(9'h002, ok);
    send_word(9'h0AA, ok);
    send_word(9'h155, ok);
    wait_done(cyc);
    checks++; if (cyc != 4 || err0 !== 1'b0) begin errors++; $display("FAIL verify_clean got cycles=%0d err=%b exp 4 0", cyc, err0); end
  endtask
`endif

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 9'h000;
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_midreset();
`ifdef PROG_LOADER_VERIFY_EN
    test_verify();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
